// File: rtl/apu_wr_queue.sv
// APU write-back queue: buffers (dest reg, data) results and drains them over the req/ack write port.
// Optional macro APU_WB_FWD_EN adds the q_data forwarding output (youngest matching entry).
module apu_wr_queue #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_SEL_WIDTH = 5,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [REG_SEL_WIDTH-1:0] push_sel,
    input  logic [DATA_WIDTH-1:0]    push_data,
    output logic                     apu_wr_req,
    output logic [REG_SEL_WIDTH-1:0] apu_wr_sel,
    output logic [DATA_WIDTH-1:0]    apu_wr_data,
    input  logic                     apu_ack,
    input  logic [REG_SEL_WIDTH-1:0] q_sel,
    output logic                     q_pending,
`ifdef APU_WB_FWD_EN
    output logic [DATA_WIDTH-1:0]    q_data,
`endif
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [PTR_W:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]           rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [REG_SEL_WIDTH-1:0] sel_q  [DEPTH];
    logic [REG_SEL_WIDTH-1:0] sel_d  [DEPTH];
    logic [DATA_WIDTH-1:0]    data_q [DEPTH];
    logic [DATA_WIDTH-1:0]    data_d [DEPTH];
    logic [REG_SEL_WIDTH-1:0] wr_sel_q, wr_sel_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;

    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic             fifo_empty;
    logic             full;
    logic             push_fire;
    logic             alloc;
    logic             pop;

    assign wr_idx     = wr_ptr_q[PTR_W-1:0];
    assign rd_idx     = rd_ptr_q[PTR_W-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
    assign push_ready = !full;
    assign push_fire  = push_valid && push_ready;
    // x0 is hardwired, so a push to it is handshaken but never stored.
    assign alloc      = push_fire && (push_sel != '0);
    assign pop        = (state_q == REQ) && apu_ack;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        sel_d    = sel_q;
        data_d   = data_q;
        if (alloc) begin
            sel_d[wr_idx]   = push_sel;
            data_d[wr_idx]  = push_data;
            valid_d[wr_idx] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            valid_d[rd_idx] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_ONE;
        end
    end

    // GAP swallows the duplicate ack the register file returns for its second sample of req.
    always_comb begin
        state_d   = state_q;
        wr_sel_d  = wr_sel_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = REQ;
                    wr_sel_d  = sel_q[rd_idx];
                    wr_data_d = data_q[rd_idx];
                end
            end
            REQ: begin
                if (apu_ack) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (!fifo_empty) begin
                    state_d   = REQ;
                    wr_sel_d  = sel_q[rd_idx];
                    wr_data_d = data_q[rd_idx];
                end else begin
                    state_d   = IDLE;
                    wr_sel_d  = '0;
                    wr_data_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                wr_sel_d  = '0;
                wr_data_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            valid_q   <= '0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sel_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            valid_q   <= valid_d;
            wr_sel_q  <= wr_sel_d;
            wr_data_q <= wr_data_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        q_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (sel_q[i] == q_sel) && (q_sel != '0)) begin
                q_pending = 1'b1;
            end
        end
    end

`ifdef APU_WB_FWD_EN
    // Valid entries are contiguous and end at wr_ptr-1, so the first hit walking back is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             hit;
        q_data = '0;
        hit    = 1'b0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = wr_idx - PTR_W'(k + 1);
            if (!hit && valid_q[idx] && (sel_q[idx] == q_sel) && (q_sel != '0)) begin
                hit    = 1'b1;
                q_data = data_q[idx];
            end
        end
    end
`endif

    assign apu_wr_req  = (state_q == REQ);
    assign apu_wr_sel  = wr_sel_q;
    assign apu_wr_data = wr_data_q;
    assign empty       = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_apu_wr_queue.sv
// Directed self-checking bench for apu_wr_queue; models the register file ack as req delayed one cycle.
module tb_apu_wr_queue;

    localparam int DW = 32;
    localparam int SW = 5;

    logic          clk;
    logic          rst;
    logic          push_valid;
    logic          push_ready;
    logic [SW-1:0] push_sel;
    logic [DW-1:0] push_data;
    logic          apu_wr_req;
    logic [SW-1:0] apu_wr_sel;
    logic [DW-1:0] apu_wr_data;
    logic          apu_ack;
    logic [SW-1:0] q_sel;
    logic          q_pending;
`ifdef APU_WB_FWD_EN
    logic [DW-1:0] q_data;
`endif
    logic          empty;

    logic ack_en;
    logic req_seen;
    int   checks;
    int   fails;

    apu_wr_queue #(.DATA_WIDTH(DW), .REG_SEL_WIDTH(SW), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_sel    (push_sel),
        .push_data   (push_data),
        .apu_wr_req  (apu_wr_req),
        .apu_wr_sel  (apu_wr_sel),
        .apu_wr_data (apu_wr_data),
        .apu_ack     (apu_ack),
        .q_sel       (q_sel),
        .q_pending   (q_pending),
`ifdef APU_WB_FWD_EN
        .q_data      (q_data),
`endif
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file side: ack is the req it sampled at the previous edge, gated by ack_en.
    initial begin
        apu_ack  = 1'b0;
        req_seen = 1'b0;
        forever begin
            @(negedge clk);
            req_seen = apu_wr_req;
            @(posedge clk);
            #1;
            apu_ack = ack_en && req_seen;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        push_valid = 1'b0;
        ack_en     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst        = 1'b0;
        push_valid = 1'b1;
        push_sel   = 5'd3;
        push_data  = 32'h0000_0055;
        q_sel      = 5'd3;
        repeat (2) @(negedge clk);
        checks++; if (apu_wr_req !== 1'b0) begin fails++; $display("[TB] FAIL rst_req: got %b expected 0", apu_wr_req); end
        checks++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL rst_empty: got %b expected 1", empty); end
        checks++; if (push_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_push_ready: got %b expected 1", push_ready); end
        checks++; if (q_pending !== 1'b0) begin fails++; $display("[TB] FAIL rst_q_pending: got %b expected 0", q_pending); end
        checks++; if (apu_wr_sel !== 5'd0) begin fails++; $display("[TB] FAIL rst_wr_sel: got %h expected 0", apu_wr_sel); end
        checks++; if (apu_wr_data !== 32'd0) begin fails++; $display("[TB] FAIL rst_wr_data: got %h expected 0", apu_wr_data); end
        rst        = 1'b1;
        push_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL rst_nothing_queued: empty got %b expected 1", empty); end
        checks++; if (apu_wr_req !== 1'b0) begin fails++; $display("[TB] FAIL rst_no_req: got %b expected 0", apu_wr_req); end
    endtask

    task automatic test_single_write();
        ack_en     = 1'b1;
        push_valid = 1'b1;
        push_sel   = 5'd5;
        push_data  = 32'hDEAD_BEEF;
        q_sel      = 5'd5;
        @(negedge clk);
        push_valid = 1'b0;
        checks++; if (q_pending !== 1'b1) begin fails++; $display("[TB] FAIL sw_pending_after_push: got %b expected 1", q_pending); end
        checks++; if (apu_wr_req !== 1'b0) begin fails++; $display("[TB] FAIL sw_req_push_cycle: got %b expected 0", apu_wr_req); end
        checks++; if (empty !== 1'b0) begin fails++; $display("[TB] FAIL sw_not_empty: got %b expected 0", empty); end
        @(negedge clk);
        checks++; if (apu_wr_req !== 1'b1) begin fails++; $display("[TB] FAIL sw_req_rise: got %b expected 1", apu_wr_req); end
        checks++; if (apu_wr_sel !== 5'd5) begin fails++; $display("[TB] FAIL sw_sel: got %h expected 5", apu_wr_sel); end
        checks++; if (apu_wr_data !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL sw_data: got %h expected deadbeef", apu_wr_data); end
        @(negedge clk);
        checks++; if (apu_wr_req !== 1'b1) begin fails++; $display("[TB] FAIL sw_req_held: got %b expected 1", apu_wr_req); end
        checks++; if (q_pending !== 1'b1) begin fails++; $display("[TB] FAIL sw_pending_inflight: got %b expected 1", q_pending); end
        @(negedge clk);
        checks++; if (apu_wr_req !== 1'b0) begin fails++; $display("[TB] FAIL sw_gap_req: got %b expected 0", apu_wr_req); end
        checks++; if (q_pending !== 1'b0) begin fails++; $display("[TB] FAIL sw_pending_cleared: got %b expected 0", q_pending); end
        checks++; if (apu_wr_sel !== 5'd5) begin fails++; $display("[TB] FAIL sw_gap_sel_held: got %h expected 5", apu_wr_sel); end
        @(negedge clk);
        checks++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL sw_empty_after: got %b expected 1", empty); end
        checks++; if (apu_wr_sel !== 5'd0) begin fails++; $display("[TB] FAIL sw_idle_sel: got %h expected 0", apu_wr_sel); end
        checks++; if (apu_wr_data !== 32'd0) begin fails++; $display("[TB] FAIL sw_idle_data: got %h expected 0", apu_wr_data); end
        ack_en = 1'b0;
    endtask

    task automatic test_fill();
        logic [SW-1:0] rs [4];
        logic [DW-1:0] rdat [4];
        int            rc [4];
        int            n;
        logic          prev;
        ack_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push_valid = 1'b1;
            push_sel   = SW'(i);
            push_data  = 32'h100 + DW'(i);
            @(negedge clk);
        end
        q_sel = 5'd3;
        #1;
        checks++; if (push_ready !== 1'b0) begin fails++; $display("[TB] FAIL fill_full: push_ready got %b expected 0", push_ready); end
        checks++; if (q_pending !== 1'b1) begin fails++; $display("[TB] FAIL fill_pending3: got %b expected 1", q_pending); end
        push_sel  = 5'd9;
        push_data = 32'h999;
        @(negedge clk);
        push_valid = 1'b0;
        q_sel      = 5'd9;
        #1;
        checks++; if (q_pending !== 1'b0) begin fails++; $display("[TB] FAIL fill_refused: q_pending(9) got %b expected 0", q_pending); end
        checks++; if (push_ready !== 1'b0) begin fails++; $display("[TB] FAIL fill_still_full: got %b expected 0", push_ready); end
        checks++; if (apu_wr_req !== 1'b1) begin fails++; $display("[TB] FAIL fill_req_waiting: got %b expected 1", apu_wr_req); end
        checks++; if (apu_wr_sel !== 5'd1) begin fails++; $display("[TB] FAIL fill_head_sel: got %h expected 1", apu_wr_sel); end
        checks++; if (apu_wr_data !== 32'h101) begin fails++; $display("[TB] FAIL fill_head_data: got %h expected 101", apu_wr_data); end
        ack_en = 1'b1;
        prev   = 1'b1;
        n      = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (apu_wr_req && !prev) begin
                if (n < 4) begin
                    rs[n]   = apu_wr_sel;
                    rdat[n] = apu_wr_data;
                    rc[n]   = c;
                end
                n++;
            end
            prev = apu_wr_req;
        end
        checks++; if (n !== 3) begin fails++; $display("[TB] FAIL fill_drain_count: got %0d expected 3", n); end
        if (n >= 3) begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (rs[k] !== SW'(k + 2)) begin fails++; $display("[TB] FAIL fill_order_sel%0d: got %h expected %h", k, rs[k], k + 2); end
                checks++; if (rdat[k] !== (32'h100 + DW'(k + 2))) begin fails++; $display("[TB] FAIL fill_order_data%0d: got %h expected %h", k, rdat[k], 32'h100 + k + 2); end
            end
            checks++; if (rc[1] - rc[0] !== 3) begin fails++; $display("[TB] FAIL fill_spacing_a: got %0d expected 3", rc[1] - rc[0]); end
            checks++; if (rc[2] - rc[1] !== 3) begin fails++; $display("[TB] FAIL fill_spacing_b: got %0d expected 3", rc[2] - rc[1]); end
        end
        checks++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL fill_empty_end: got %b expected 1", empty); end
        ack_en = 1'b0;
    endtask

    task automatic test_x0_discard();
        logic seen;
        ack_en     = 1'b1;
        q_sel      = 5'd0;
        push_valid = 1'b1;
        push_sel   = 5'd0;
        push_data  = 32'h1234;
        #1;
        checks++; if (push_ready !== 1'b1) begin fails++; $display("[TB] FAIL x0_push_ready: got %b expected 1", push_ready); end
        @(negedge clk);
        push_valid = 1'b0;
        checks++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL x0_empty: got %b expected 1", empty); end
        checks++; if (q_pending !== 1'b0) begin fails++; $display("[TB] FAIL x0_q_pending: got %b expected 0", q_pending); end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (apu_wr_req) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("[TB] FAIL x0_no_req: req seen %b expected 0", seen); end
        ack_en = 1'b0;
    endtask

    task automatic test_stale_ack();
        logic [SW-1:0] rs [4];
        logic [DW-1:0] rdat [4];
        int            dur [4];
        int            n;
        logic          prev;
        for (int k = 0; k < 4; k++) dur[k] = 0;
        ack_en = 1'b1;
        prev   = apu_wr_req;
        n      = 0;
        for (int c = 0; c < 36; c++) begin
            if (c < 3) begin
                push_valid = 1'b1;
                push_sel   = SW'(10 + c);
                push_data  = 32'hA0 + DW'(c);
            end else begin
                push_valid = 1'b0;
            end
            @(negedge clk);
            if (apu_wr_req) begin
                if (!prev) begin
                    if (n < 4) begin
                        rs[n]   = apu_wr_sel;
                        rdat[n] = apu_wr_data;
                    end
                    n++;
                end
                if (n >= 1 && n <= 4) dur[n-1]++;
            end
            prev = apu_wr_req;
        end
        checks++; if (n !== 3) begin fails++; $display("[TB] FAIL stale_count: got %0d expected 3", n); end
        if (n >= 3) begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (rs[k] !== SW'(10 + k)) begin fails++; $display("[TB] FAIL stale_sel%0d: got %h expected %h", k, rs[k], 10 + k); end
                checks++; if (rdat[k] !== (32'hA0 + DW'(k))) begin fails++; $display("[TB] FAIL stale_data%0d: got %h expected %h", k, rdat[k], 32'hA0 + k); end
                checks++; if (dur[k] !== 2) begin fails++; $display("[TB] FAIL stale_req_len%0d: got %0d expected 2", k, dur[k]); end
            end
        end
        checks++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL stale_empty_end: got %b expected 1", empty); end
        ack_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic any_pending;
        logic seen;
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1;
            push_sel   = SW'(13 + i);
            push_data  = 32'hC0 + DW'(i);
            @(negedge clk);
        end
        push_valid = 1'b0;
        checks++; if (apu_wr_req !== 1'b1) begin fails++; $display("[TB] FAIL mr_in_req: got %b expected 1", apu_wr_req); end
        ack_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        ack_en = 1'b0;
        checks++; if (apu_wr_req !== 1'b0) begin fails++; $display("[TB] FAIL mr_req: got %b expected 0", apu_wr_req); end
        checks++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL mr_empty: got %b expected 1", empty); end
        checks++; if (push_ready !== 1'b1) begin fails++; $display("[TB] FAIL mr_push_ready: got %b expected 1", push_ready); end
        any_pending = 1'b0;
        for (int s = 0; s < 32; s++) begin
            q_sel = SW'(s);
            #1;
            if (q_pending) any_pending = 1'b1;
        end
        checks++; if (any_pending !== 1'b0) begin fails++; $display("[TB] FAIL mr_pending_all: got %b expected 0", any_pending); end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (apu_wr_req) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("[TB] FAIL mr_no_req_after: got %b expected 0", seen); end
    endtask

    task automatic test_duplicates();
        ack_en     = 1'b0;
        push_valid = 1'b1;
        push_sel   = 5'd7;
        push_data  = 32'hA;
        @(negedge clk);
        push_data  = 32'hB;
        @(negedge clk);
        push_valid = 1'b0;
        q_sel      = 5'd7;
        #1;
        checks++; if (q_pending !== 1'b1) begin fails++; $display("[TB] FAIL dup_pending7: got %b expected 1", q_pending); end
`ifdef APU_WB_FWD_EN
        checks++; if (q_data !== 32'hB) begin fails++; $display("[TB] FAIL dup_fwd_youngest: got %h expected b", q_data); end
`endif
        q_sel = 5'd6;
        #1;
        checks++; if (q_pending !== 1'b0) begin fails++; $display("[TB] FAIL dup_pending6: got %b expected 0", q_pending); end
`ifdef APU_WB_FWD_EN
        checks++; if (q_data !== 32'h0) begin fails++; $display("[TB] FAIL dup_fwd_none: got %h expected 0", q_data); end
`endif
        do_reset();
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        rst        = 1'b0;
        push_valid = 1'b0;
        push_sel   = '0;
        push_data  = '0;
        q_sel      = '0;
        ack_en     = 1'b0;
        $display("[TB] starting apu_wr_queue bench");
        test_reset();
        test_single_write();
        test_fill();
        test_x0_discard();
        test_stale_ack();
        test_mid_reset();
        test_duplicates();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
